ps2_scancode_rx: RTL
====================

PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal synchronized samples of ps2_clk required before the filtered clock changes level.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 25000: clk25 cycles without a filtered falling edge before a partial frame is aborted (1 ms).
REQ-003 SHALL have port clk25  input  1  system clock, 25 MHz.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ps2_clk  input  1  raw keyboard clock, asynchronous to clk25.
REQ-006 SHALL have port ps2_data  input  1  raw keyboard data, asynchronous to clk25.
REQ-007 SHALL have port scancode  output  8  last accepted byte, held until the next accepted byte.
REQ-008 SHALL have port found  output  1  one-cycle pulse marking a new scancode.
REQ-009 SHALL have port parity_err  output  1  one-cycle pulse on a frame rejected for parity.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a frame rejected for stop bit 0 or timeout.

Function
REQ-011 SHALL pass ps2_clk and ps2_data through two-flop synchronizers before any use.
REQ-012 SHALL change the filtered clock only after FILTER_LEN consecutive synchronized samples at the opposite level; glitches shorter than this SHALL be ignored.
REQ-013 SHALL register a falling-edge strobe, one cycle wide, when the filtered clock goes 1->0; synchronized ps2_data is sampled in the strobe cycle.
REQ-014 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-015 In IDLE, a strobe with data 0 SHALL go to DATA with bit count 0; a strobe with data 1 SHALL stay in IDLE with no output pulse.
REQ-016 In DATA, each strobe SHALL shift the sampled bit into the receive register LSB first; after the 8th bit, the state SHALL go to PARITY.
REQ-017 In PARITY, the strobe SHALL store the parity bit; the state SHALL go to STOP.
REQ-018 Parity SHALL be odd: XOR of 8 data bits and the parity bit equals 1.
REQ-019 In STOP, the strobe SHALL return to IDLE and apply these rules:
- stop bit 0: frame_err pulses.
- stop bit 1 with bad parity: parity_err pulses.
- stop bit 1 with good parity: accept the frame.
REQ-020 On acceptance, scancode SHALL update and found SHALL pulse high in the cycle after the stop-bit strobe, for exactly one cycle.
REQ-021 Error checks SHALL have priority: frame_err over parity_err; a rejected frame SHALL never change scancode or assert found.
REQ-022 In DATA, PARITY or STOP, a 15-bit idle counter SHALL count cycles since the last strobe and reset to 0 on each strobe.
REQ-023 When the idle counter reaches TIMEOUT_CYC-1, the block SHALL return to IDLE and pulse frame_err.
REQ-024 If a strobe and the timeout occur in the same cycle, the strobe SHALL win.
REQ-025 found, parity_err and frame_err SHALL never assert in the same cycle.
REQ-026 The block SHALL be receive-only and SHALL never drive ps2_clk or ps2_data.

Reset
REQ-027 Asserting reset SHALL asynchronously force:
- state IDLE;
- scancode 8'h00;
- found, parity_err and frame_err 0;
- counters 0;
- filtered clock and synchronizers 1 (bus idle).
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; the first frame after release SHALL decode normally.

Configuration
REQ-029 With macro PS2_BREAK_FILTER_EN defined, an accepted 8'hF0 SHALL NOT assert found and SHALL arm a skip flag.
REQ-030 With the macro defined, the next accepted byte SHALL clear the skip flag without asserting found or updating scancode; reset SHALL also clear the flag.
REQ-031 Without the macro, every accepted byte, including 8'hF0, SHALL update scancode and pulse found.

Verification
REQ-032 Frame 8'h16, odd parity, stop 1, at 2000-cycle half-period -> found one cycle after the stop strobe; scancode=8'h16; no error pulses.
REQ-033 Frame 8'h1E with parity flipped -> parity_err one pulse; found stays 0; scancode keeps its prior value.
REQ-034 Frame 8'h2D with stop bit 0 -> frame_err one pulse; no found.
REQ-035 Start bit plus 4 data bits, then clock held high 30000 cycles -> frame_err at the idle count TIMEOUT_CYC-1; the next full frame 8'h15 is accepted.
REQ-036 3-cycle low glitches on ps2_clk during IDLE and DATA -> no strobe, no state change; a following valid frame 8'h26 is decoded correctly.
REQ-037 Sequence 8'h35, 8'hF0, 8'h35 -> with PS2_BREAK_FILTER_EN, exactly one found (8'h35); without it, three found pulses (8'h35, 8'hF0, 8'h35).

Source files
------------

// File: rtl/ps2_scancode_rx.sv
// ---------------------------------------------------------------------------
// ps2_scancode_rx
//
// Receive-only PS/2 keyboard frame decoder. The raw keyboard clock and data
// are brought into the clk25 domain through two-flop synchronizers. The
// clock is then glitch-filtered, and each filtered falling edge shifts one
// bit of an 11-bit frame (start, 8 data LSB first, odd parity, stop).
// Accepted bytes appear on scancode together with a one-cycle found pulse.
// Rejected frames pulse parity_err or frame_err instead.
//
// Parameters:
//   FILTER_LEN   consecutive equal synchronized ps2_clk samples needed
//                before the filtered clock changes level
//   TIMEOUT_CYC  clk25 cycles without a falling edge before a partial
//                frame is abandoned (must fit the 15-bit idle counter)
//
// Ports:
//   clk25       in   system clock (25 MHz)
//   reset       in   asynchronous, active-high reset
//   ps2_clk     in   raw keyboard clock (asynchronous)
//   ps2_data    in   raw keyboard data (asynchronous)
//   scancode    out  [7:0] last accepted byte, held until the next one
//   found       out  one-cycle pulse: new scancode
//   parity_err  out  one-cycle pulse: frame rejected for parity
//   frame_err   out  one-cycle pulse: frame rejected (stop bit 0 / timeout)
//
// Configuration macro:
//   PS2_BREAK_FILTER_EN  when defined, an accepted 8'hF0 (break prefix) and
//                        the byte following it are swallowed: neither pulses
//                        found nor updates scancode.
// ---------------------------------------------------------------------------
module ps2_scancode_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 25000
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scancode,
  output logic       found,
  output logic       parity_err,
  output logic       frame_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam int          FCW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCW-1:0] FCNT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [14:0] IDLE_LAST = 15'(TIMEOUT_CYC - 1);

  // Synchronizers and clock filter
  logic [1:0]     clk_sync_q, data_sync_q;
  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           strobe_q, strobe_d;

  // Frame FSM
  logic [1:0]  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [14:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]  scancode_q, scancode_d;
  logic        found_q, found_d;
  logic        parity_err_q, parity_err_d;
  logic        frame_err_q, frame_err_d;
`ifdef PS2_BREAK_FILTER_EN
  logic        skip_q, skip_d;
`endif

  logic clk_s, data_s;
  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  // Filter: count consecutive samples that disagree with the filtered level;
  // any agreeing sample restarts the count, so short glitches never flip it.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    filt_d   = filt_q;
    fcnt_d   = '0;
    strobe_d = 1'b0;
    if (clk_s != filt_q) begin
      if (fcnt_q == FCNT_LAST) begin
        filt_d   = clk_s;
        strobe_d = filt_q;  // only a 1->0 change produces a strobe
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    idle_cnt_d   = '0;
    scancode_d   = scancode_q;
    found_d      = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
    skip_d       = skip_q;
`endif

    if (state_q == ST_IDLE) begin
      if (strobe_q && !data_s) begin
        state_d   = ST_DATA;
        bit_cnt_d = 3'd0;
      end
    end else if (strobe_q) begin
      // A strobe always wins over a timeout landing in the same cycle.
      unique case (state_q)
        ST_DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = data_s;
          state_d = ST_STOP;
        end
        default: begin  // ST_STOP
          state_d = ST_IDLE;
          if (!data_s) begin
            frame_err_d = 1'b1;
          end else if (!(^{shift_q, par_q})) begin
            parity_err_d = 1'b1;
          end else begin
`ifdef PS2_BREAK_FILTER_EN
            if (skip_q) begin
              skip_d = 1'b0;
            end else if (shift_q == 8'hF0) begin
              skip_d = 1'b1;
            end else begin
              scancode_d = shift_q;
              found_d    = 1'b1;
            end
`else
            scancode_d = shift_q;
            found_d    = 1'b1;
`endif
          end
        end
      endcase
    end else if (idle_cnt_q == IDLE_LAST) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
    end else begin
      idle_cnt_d = idle_cnt_q + 15'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      clk_sync_q   <= 2'b11;
      data_sync_q  <= 2'b11;
      filt_q       <= 1'b1;
      fcnt_q       <= '0;
      strobe_q     <= 1'b0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      idle_cnt_q   <= 15'd0;
      scancode_q   <= 8'h00;
      found_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], ps2_clk};
      data_sync_q  <= {data_sync_q[0], ps2_data};
      filt_q       <= filt_d;
      fcnt_q       <= fcnt_d;
      strobe_q     <= strobe_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      idle_cnt_q   <= idle_cnt_d;
      scancode_q   <= scancode_d;
      found_q      <= found_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) skip_q <= 1'b0;
    else       skip_q <= skip_d;
  end
`endif

  assign scancode   = scancode_q;
  assign found      = found_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule
